// File: rtl/phys_free_list_pkg.sv
// Shared definitions for the physical-register free list and its helpers.
package phys_free_list_pkg;

  localparam int CDB_BITS = 6;
  localparam int N_WAY    = 2;
  localparam int N_ROB    = 8;
  localparam int N_PHYS   = 2 ** CDB_BITS;
  localparam int N_ARCH   = 32;

  typedef logic [CDB_BITS-1:0] PHYS_TAG;

  // Tag 0 means "no tag"; it is never handed out and never reclaimed.
  localparam PHYS_TAG TAG_ZERO = '0;

endpackage

// File: rtl/phys_free_list_ffs_multi.sv
// Combinational "find first N_SEL set bits" scanner, lowest index first.
// Also intended for reuse by the reservation-station issue selector.
module ffs_multi #(
  parameter int N_BITS   = 64,
  parameter int N_SEL    = 2,
  parameter int IDX_BITS = $clog2(N_BITS)
) (
  input  logic [N_BITS-1:0]              vec,
  output logic [N_SEL-1:0][IDX_BITS-1:0] idx,
  output logic [N_SEL-1:0]               valid
);

  int found;

  // Walk the vector upward; the n-th set bit lands in output slot n.
  always_comb begin
    idx   = '0;
    valid = '0;
    found = 0;
    for (int i = 0; i < N_BITS; i++) begin
      if (vec[i]) begin
        for (int k = 0; k < N_SEL; k++) begin
          if (k == found) begin
            idx[k]   = IDX_BITS'(i);
            valid[k] = 1'b1;
          end
        end
        if (found < N_SEL) found = found + 1;
      end
    end
  end

endmodule

// File: rtl/phys_free_list.sv
// Physical-register free list: bitmap of free tags, in-order multi-way
// allocation, and reclaim from ROB retirement and branch flushes.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int N_WAY    = phys_free_list_pkg::N_WAY,
  parameter int N_ROB    = phys_free_list_pkg::N_ROB,
  parameter int TAG_BITS = phys_free_list_pkg::CDB_BITS,
  parameter int N_ARCH   = phys_free_list_pkg::N_ARCH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_WAY-1:0]                 alloc_req,
  output logic [N_WAY-1:0]                 alloc_grant,
  output logic [N_WAY-1:0][TAG_BITS-1:0]   alloc_tag,
  input  logic [N_WAY-1:0]                 retire_valid,
  input  logic [N_WAY-1:0][TAG_BITS-1:0]   retire_told,
  input  logic                             branch_haz,
  input  logic [N_ROB-1:0][TAG_BITS-1:0]   free_list_haz,
  output logic [TAG_BITS:0]                free_count,
  output logic [$clog2(N_WAY):0]           avail,
  output logic                             dbl_free_err
);

  localparam int NUM_TAGS   = 2 ** TAG_BITS;
  localparam int AVAIL_BITS = $clog2(N_WAY) + 1;
  localparam logic [NUM_TAGS-1:0] FREE_RESET = {NUM_TAGS{1'b1}} << (N_ARCH + 1);
  localparam logic [TAG_BITS:0]   CNT_RESET  = (TAG_BITS + 1)'(NUM_TAGS - 1 - N_ARCH);
  localparam logic [TAG_BITS-1:0] NO_TAG     = TAG_BITS'(TAG_ZERO);

  logic [NUM_TAGS-1:0] free_q, free_d;
  logic [TAG_BITS:0]   cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_TAGS-1:0]               scan_vec;
  logic [N_WAY-1:0][TAG_BITS-1:0]    ffs_idx;
  logic [N_WAY-1:0]                  ffs_valid;
  logic [NUM_TAGS-1:0]               granted_mask;
  logic [NUM_TAGS-1:0]               freed_mask;
  logic [NUM_TAGS-1:0]               newly_free;
  int                                used;
  logic                              blocked;
  logic                              got;

  assign scan_vec = {free_q[NUM_TAGS-1:1], 1'b0};

  ffs_multi #(
    .N_BITS   (NUM_TAGS),
    .N_SEL    (N_WAY),
    .IDX_BITS (TAG_BITS)
  ) u_ffs (
    .vec   (scan_vec),
    .idx   (ffs_idx),
    .valid (ffs_valid)
  );

  // In-order grant: each requesting slot takes the next lowest free tag; the first failure blocks the rest.
  always_comb begin
    alloc_grant  = '0;
    alloc_tag    = '0;
    granted_mask = '0;
    used         = 0;
    blocked      = 1'b0;
    got          = 1'b0;
    for (int k = 0; k < N_WAY; k++) begin
      if (!reset && !branch_haz && alloc_req[k] && !blocked) begin
        got = 1'b0;
        for (int j = 0; j < N_WAY; j++) begin
          if (j == used && ffs_valid[j]) begin
            alloc_grant[k]           = 1'b1;
            alloc_tag[k]             = ffs_idx[j];
            granted_mask[ffs_idx[j]] = 1'b1;
            got                      = 1'b1;
          end
        end
        if (got) used = used + 1;
        else     blocked = 1'b1;
      end
    end
  end

  // Gather retired and squashed tags, flagging any tag that is already free or freed twice.
  always_comb begin
    freed_mask = '0;
    err_d      = err_q;
    for (int i = 0; i < N_WAY; i++) begin
      if (retire_valid[i] && retire_told[i] != NO_TAG) begin
        if (free_q[retire_told[i]] || freed_mask[retire_told[i]]) err_d = 1'b1;
        freed_mask[retire_told[i]] = 1'b1;
      end
    end
    if (branch_haz) begin
      for (int e = 1; e < N_ROB; e++) begin
        if (free_list_haz[e] != NO_TAG) begin
          if (free_q[free_list_haz[e]] || freed_mask[free_list_haz[e]]) err_d = 1'b1;
          freed_mask[free_list_haz[e]] = 1'b1;
        end
      end
    end
  end

  // Next bitmap and count; only tags that were busy after this cycle's grants add to the count.
  always_comb begin
    free_d     = (free_q & ~granted_mask) | freed_mask;
    newly_free = freed_mask & ~(free_q & ~granted_mask);
    cnt_d      = cnt_q - (TAG_BITS + 1)'($countones(alloc_grant))
                       + (TAG_BITS + 1)'($countones(newly_free));
  end

  // State registers with synchronous reset to the architectural mapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      free_q <= FREE_RESET;
      cnt_q  <= CNT_RESET;
      err_q  <= 1'b0;
    end else begin
      free_q <= free_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign free_count   = cnt_q;
  assign dbl_free_err = err_q;
  assign avail        = (cnt_q >= (TAG_BITS + 1)'(N_WAY)) ? AVAIL_BITS'(N_WAY)
                                                          : AVAIL_BITS'(cnt_q);

endmodule

// File: tb/tb_phys_free_list.sv
// Directed self-checking bench for phys_free_list (N_WAY=2, 6-bit tags, 8-entry ROB).
module tb_phys_free_list;

  logic             clock;
  logic             reset;
  logic [1:0]       alloc_req;
  logic [1:0]       alloc_grant;
  logic [1:0][5:0]  alloc_tag;
  logic [1:0]       retire_valid;
  logic [1:0][5:0]  retire_told;
  logic             branch_haz;
  logic [7:0][5:0]  free_list_haz;
  logic [6:0]       free_count;
  logic [1:0]       avail;
  logic             dbl_free_err;

  int checks;
  int errors;

  phys_free_list #(
    .N_WAY    (2),
    .N_ROB    (8),
    .TAG_BITS (6),
    .N_ARCH   (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .alloc_req     (alloc_req),
    .alloc_grant   (alloc_grant),
    .alloc_tag     (alloc_tag),
    .retire_valid  (retire_valid),
    .retire_told   (retire_told),
    .branch_haz    (branch_haz),
    .free_list_haz (free_list_haz),
    .free_count    (free_count),
    .avail         (avail),
    .dbl_free_err  (dbl_free_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The registered count must always match the number of set bits in the bitmap.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if ($countones(dut.free_q) != int'(free_count)) begin
        errors++;
        $display("[TB] FAIL count_invariant got %0d want %0d", free_count, $countones(dut.free_q));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_req     = '0;
    retire_valid  = '0;
    retire_told   = '0;
    branch_haz    = 1'b0;
    free_list_haz = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (free_count !== 7'd31) begin errors++; $display("[TB] FAIL reset_count got %0d want 31", free_count); end
    checks++;
    if (avail !== 2'd2) begin errors++; $display("[TB] FAIL reset_avail got %0d want 2", avail); end
    checks++;
    if (dbl_free_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0d want 0", dbl_free_err); end
    reset = 1'b1;
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 2'b00 || alloc_tag !== '0) begin
      errors++; $display("[TB] FAIL reset_grant got %b/%h want 00/0", alloc_grant, alloc_tag);
    end
    tick();
    reset = 1'b0;
    alloc_req = 2'b00;
    checks++;
    if (free_count !== 7'd31) begin errors++; $display("[TB] FAIL reset_override_count got %0d want 31", free_count); end
  endtask

  task automatic test_alloc_pair();
    do_reset();
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 2'b11 || alloc_tag[1] !== 6'd34 || alloc_tag[0] !== 6'd33) begin
      errors++; $display("[TB] FAIL pair_first got %b {%0d,%0d} want 11 {34,33}", alloc_grant, alloc_tag[1], alloc_tag[0]);
    end
    tick();
    checks++;
    if (free_count !== 7'd29) begin errors++; $display("[TB] FAIL pair_count got %0d want 29", free_count); end
    checks++;
    if (alloc_grant !== 2'b11 || alloc_tag[1] !== 6'd36 || alloc_tag[0] !== 6'd35) begin
      errors++; $display("[TB] FAIL pair_second got %b {%0d,%0d} want 11 {36,35}", alloc_grant, alloc_tag[1], alloc_tag[0]);
    end
    tick();
    alloc_req = 2'b00;
    checks++;
    if (free_count !== 7'd27) begin errors++; $display("[TB] FAIL pair_count2 got %0d want 27", free_count); end
  endtask

  task automatic test_alloc_hole();
    do_reset();
    alloc_req = 2'b10;
    #1;
    checks++;
    if (alloc_grant !== 2'b10 || alloc_tag[1] !== 6'd33 || alloc_tag[0] !== 6'd0) begin
      errors++; $display("[TB] FAIL hole_slot1 got %b {%0d,%0d} want 10 {33,0}", alloc_grant, alloc_tag[1], alloc_tag[0]);
    end
    tick();
    alloc_req = 2'b01;
    #1;
    checks++;
    if (alloc_grant !== 2'b01 || alloc_tag[0] !== 6'd34 || alloc_tag[1] !== 6'd0) begin
      errors++; $display("[TB] FAIL hole_slot0 got %b {%0d,%0d} want 01 {0,34}", alloc_grant, alloc_tag[1], alloc_tag[0]);
    end
    tick();
    alloc_req = 2'b00;
    checks++;
    if (free_count !== 7'd29) begin errors++; $display("[TB] FAIL hole_count got %0d want 29", free_count); end
  endtask

  task automatic test_drain_and_retire();
    do_reset();
    alloc_req = 2'b11;
    for (int c = 0; c < 15; c++) tick();
    alloc_req = 2'b00;
    checks++;
    if (free_count !== 7'd1 || avail !== 2'd1) begin
      errors++; $display("[TB] FAIL drain_one got %0d/%0d want 1/1", free_count, avail);
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 2'b01 || alloc_tag[0] !== 6'd63 || alloc_tag[1] !== 6'd0) begin
      errors++; $display("[TB] FAIL drain_last got %b {%0d,%0d} want 01 {0,63}", alloc_grant, alloc_tag[1], alloc_tag[0]);
    end
    tick();
    checks++;
    if (free_count !== 7'd0 || avail !== 2'd0) begin
      errors++; $display("[TB] FAIL drain_empty got %0d/%0d want 0/0", free_count, avail);
    end
    checks++;
    if (alloc_grant !== 2'b00 || alloc_tag !== '0) begin
      errors++; $display("[TB] FAIL empty_grant got %b/%h want 00/0", alloc_grant, alloc_tag);
    end
    alloc_req = 2'b00;
    retire_valid = 2'b11;
    retire_told[1] = 6'd5;
    retire_told[0] = 6'd0;
    tick();
    clear_inputs();
    checks++;
    if (free_count !== 7'd1 || dbl_free_err !== 1'b0) begin
      errors++; $display("[TB] FAIL retire_one got %0d/%0d want 1/0", free_count, dbl_free_err);
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 2'b01 || alloc_tag[0] !== 6'd5) begin
      errors++; $display("[TB] FAIL retire_reuse got %b tag0=%0d want 01 tag0=5", alloc_grant, alloc_tag[0]);
    end
    tick();
    alloc_req = 2'b00;
    retire_valid = 2'b11;
    retire_told[1] = 6'd7;
    retire_told[0] = 6'd6;
    tick();
    clear_inputs();
    checks++;
    if (free_count !== 7'd2 || avail !== 2'd2) begin
      errors++; $display("[TB] FAIL retire_two got %0d/%0d want 2/2", free_count, avail);
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 2'b11 || alloc_tag[1] !== 6'd7 || alloc_tag[0] !== 6'd6) begin
      errors++; $display("[TB] FAIL retire_two_reuse got %b {%0d,%0d} want 11 {7,6}", alloc_grant, alloc_tag[1], alloc_tag[0]);
    end
    tick();
    alloc_req = 2'b00;
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 2'b11;
    for (int c = 0; c < 5; c++) tick();
    branch_haz = 1'b1;
    free_list_haz[1] = 6'd40;
    free_list_haz[2] = 6'd41;
    #1;
    checks++;
    if (alloc_grant !== 2'b00 || alloc_tag !== '0) begin
      errors++; $display("[TB] FAIL flush_grant got %b/%h want 00/0", alloc_grant, alloc_tag);
    end
    tick();
    clear_inputs();
    checks++;
    if (free_count !== 7'd23 || dbl_free_err !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_count got %0d/%0d want 23/0", free_count, dbl_free_err);
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 2'b11 || alloc_tag[1] !== 6'd41 || alloc_tag[0] !== 6'd40) begin
      errors++; $display("[TB] FAIL flush_reuse got %b {%0d,%0d} want 11 {41,40}", alloc_grant, alloc_tag[1], alloc_tag[0]);
    end
    tick();
    alloc_req = 2'b00;
    branch_haz = 1'b1;
    free_list_haz[1] = 6'd42;
    retire_valid = 2'b01;
    retire_told[0] = 6'd3;
    tick();
    clear_inputs();
    checks++;
    if (free_count !== 7'd23 || dbl_free_err !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_retire got %0d/%0d want 23/0", free_count, dbl_free_err);
    end
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 2'b11 || alloc_tag[1] !== 6'd42 || alloc_tag[0] !== 6'd3) begin
      errors++; $display("[TB] FAIL flush_retire_reuse got %b {%0d,%0d} want 11 {42,3}", alloc_grant, alloc_tag[1], alloc_tag[0]);
    end
    tick();
    alloc_req = 2'b00;
  endtask

  task automatic test_double_free();
    do_reset();
    retire_valid = 2'b01;
    retire_told[0] = 6'd50;
    tick();
    clear_inputs();
    checks++;
    if (dbl_free_err !== 1'b1 || free_count !== 7'd31) begin
      errors++; $display("[TB] FAIL dbl_already_free got %0d/%0d want 1/31", dbl_free_err, free_count);
    end
    tick();
    tick();
    alloc_req = 2'b11;
    #1;
    checks++;
    if (alloc_grant !== 2'b11 || alloc_tag[0] !== 6'd33) begin
      errors++; $display("[TB] FAIL dbl_alloc_ok got %b tag0=%0d want 11 tag0=33", alloc_grant, alloc_tag[0]);
    end
    tick();
    alloc_req = 2'b00;
    checks++;
    if (dbl_free_err !== 1'b1 || free_count !== 7'd29) begin
      errors++; $display("[TB] FAIL dbl_sticky got %0d/%0d want 1/29", dbl_free_err, free_count);
    end
    do_reset();
    checks++;
    if (dbl_free_err !== 1'b0) begin errors++; $display("[TB] FAIL dbl_reset_clear got %0d want 0", dbl_free_err); end
    retire_valid = 2'b11;
    retire_told[1] = 6'd9;
    retire_told[0] = 6'd9;
    tick();
    clear_inputs();
    checks++;
    if (dbl_free_err !== 1'b1 || free_count !== 7'd32) begin
      errors++; $display("[TB] FAIL dbl_same_cycle got %0d/%0d want 1/32", dbl_free_err, free_count);
    end
    alloc_req = 2'b01;
    #1;
    checks++;
    if (alloc_grant !== 2'b01 || alloc_tag[0] !== 6'd9) begin
      errors++; $display("[TB] FAIL dbl_same_reuse got %b tag0=%0d want 01 tag0=9", alloc_grant, alloc_tag[0]);
    end
    tick();
    alloc_req = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_alloc_pair();
    test_alloc_hole();
    test_drain_and_retire();
    test_flush();
    test_double_free();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
